score: RTL and testbench
========================

Name: score

Overview:
- Pong scoreboard. Watches the ball's horizontal position and horizontal direction each clock.
- Awards exactly one point per miss: player 1 when the ball leaves past the right edge, player 2 when it leaves past the left edge.
- Sits between the ball-motion block, which drives ball_x and ball_direction, and the score display, which reads p1_score and p2_score.

Parameters:
- LEFT_LIMIT, 0: ball_x at or below this while moving left is a left miss.
- RIGHT_LIMIT, 640: ball_x at or above this is out of the playfield (screen width).
- MAX_SCORE, 9: saturation value of each score (single decimal digit).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ball_x  in  10  ball horizontal position in pixels, unsigned.
- ball_direction  in  2  bit1 = x_dir (1 = moving right, 0 = moving left); bit0 = y_dir, ignored here.
- p1_score  out  4  player 1 (left paddle) score, registered.
- p2_score  out  4  player 2 (right paddle) score, registered.

Behaviour:
- Reset, asserted asynchronously: p1_score=0, p2_score=0, armed=1. Held while reset is high.
- out_right = x_dir==1 AND ball_x >= RIGHT_LIMIT.
- out_left = x_dir==0 AND (ball_x <= LEFT_LIMIT OR ball_x >= RIGHT_LIMIT). The second term catches 10-bit underflow wrap, e.g. 3-5 gives 1022.
- Point rule, evaluated on each rising edge with reset low:
  - armed AND out_right: p1_score increments, armed clears.
  - armed AND out_left: p2_score increments, armed clears.
  - out_right and out_left are mutually exclusive by x_dir, so there is no simultaneous award.
- Latency: the score output changes on the first rising edge that samples the out condition. No combinational path from inputs to outputs.
- Re-arm: armed sets on an edge where LEFT_LIMIT < ball_x < RIGHT_LIMIT, i.e. the ball is back in the playfield (serve/reset by the ball block).
  - While disarmed, no further points are awarded, even if the ball stays out for many cycles or ball_direction toggles.
- Saturation: a score at MAX_SCORE stays at MAX_SCORE. armed still clears, so the other score is unaffected.
- Reset mid-game: both scores return to 0 and armed=1 asynchronously. If the ball is still out when reset deasserts, one point is awarded on the next edge. This is intended; the ball block recentres the ball on reset.
- ball_direction[0] has no effect on any output.

Decomposition:
- Package score_pkg:
  - SCORE_W = 4
  - default SCREEN_W = 640
  - default MAX_SCORE = 9
  - direction bit index constants: DIR_X = 1, DIR_Y = 0
- Sub-module score_counter: saturating up-counter with async active-high reset, an increment enable and a MAX parameter. Instantiated twice, one per player.
- Miss detection and the armed flag live in score itself.

Test Plan:
- Reset with ball_x=320, direction=2'b10: both scores 0 during and after reset. No change while ball_x stays in 321..639.
- Ball moving right from 320 by +5 per clock after reset release:
  - p1_score becomes 1 on the edge that first samples ball_x=640.
  - It stays 1 through ball_x=645 and 100 ns of holding out.
  - p2_score stays 0.
- Ball moving left (direction=2'b00) from 320 by -5 per clock: p2_score becomes 1 on the edge sampling ball_x=0. The subsequent wrapped value 1019 awards nothing further.
- Re-arm and repeat:
  - Miss right, set ball_x=320, miss right again: p1_score=2.
  - Repeat the sequence to reach p1_score=9; one more miss keeps it at 9, and p2_score is unchanged.
- Direction toggle while out: ball_x=700, x_dir toggling each clock after a point has been awarded. No additional points for either player until ball_x returns to 1..639.
- Reset mid-game: with p1=3, p2=2, pulse reset between clock edges. Outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/score_pkg.sv
// Shared constants for the Pong scoreboard: score width, default playfield
// geometry and the bit positions inside ball_direction.
package score_pkg;

   localparam int SCORE_W   = 4;
   localparam int SCREEN_W  = 640;
   localparam int MAX_SCORE = 9;

   localparam int DIR_X = 1;
   localparam int DIR_Y = 0;

endpackage

// File: rtl/score_counter.sv
// Saturating up-counter for one player's score; holds at MAX once reached.
module score_counter #(
   parameter int W   = score_pkg::SCORE_W,
   parameter int MAX = score_pkg::MAX_SCORE
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != MAX_V)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/score.sv
// Pong scoreboard: detects the ball leaving either edge and awards one point
// per miss, re-arming only once the ball is back inside the playfield.
module score #(
   parameter int LEFT_LIMIT  = 0,
   parameter int RIGHT_LIMIT = score_pkg::SCREEN_W,
   parameter int MAX_SCORE   = score_pkg::MAX_SCORE
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [9:0]                    ball_x,
   input  logic [1:0]                    ball_direction,
   output logic [score_pkg::SCORE_W-1:0] p1_score,
   output logic [score_pkg::SCORE_W-1:0] p2_score
);

   import score_pkg::*;

   localparam logic [9:0] L_LIM = 10'(LEFT_LIMIT);
   localparam logic [9:0] R_LIM = 10'(RIGHT_LIMIT);

   logic x_dir;
   logic out_right;
   logic out_left;
   logic in_field;
   logic armed;
   logic unused_y_dir;

   assign x_dir        = ball_direction[DIR_X];
   assign unused_y_dir = ball_direction[DIR_Y];

   // The >= R_LIM term on the left catches a position that wrapped below zero.
   assign out_right = x_dir && (ball_x >= R_LIM);
   assign out_left  = !x_dir && ((ball_x <= L_LIM) || (ball_x >= R_LIM));
   assign in_field  = (ball_x > L_LIM) && (ball_x < R_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed <= 1'b1;
      end else if (armed && (out_right || out_left)) begin
         armed <= 1'b0;
      end else if (in_field) begin
         armed <= 1'b1;
      end
   end

   score_counter #(
      .W   (SCORE_W),
      .MAX (MAX_SCORE)
   ) u_p1 (
      .clk   (clk),
      .reset (reset),
      .inc   (armed && out_right),
      .count (p1_score)
   );

   score_counter #(
      .W   (SCORE_W),
      .MAX (MAX_SCORE)
   ) u_p2 (
      .clk   (clk),
      .reset (reset),
      .inc   (armed && out_left),
      .count (p2_score)
   );

endmodule

// File: tb/tb_score.sv
// Directed bench for the Pong scoreboard with hand-computed expected scores.
module tb_score;

   logic       clk;
   logic       reset;
   logic [9:0] ball_x;
   logic [1:0] ball_direction;
   logic [3:0] p1_score;
   logic [3:0] p2_score;

   int n_checks;
   int n_errors;

   score dut (
      .clk            (clk),
      .reset          (reset),
      .ball_x         (ball_x),
      .ball_direction (ball_direction),
      .p1_score       (p1_score),
      .p2_score       (p2_score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic miss_right(input logic [1:0] dir);
      ball_direction = dir;
      ball_x = 10'd320;
      tick();
      ball_x = 10'd640;
      tick();
   endtask

   task automatic miss_left();
      ball_direction = 2'b00;
      ball_x = 10'd320;
      tick();
      ball_x = 10'd0;
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      ball_x = 10'd320;
      ball_direction = 2'b10;
      #3;
      check("reset_p1_async", p1_score, 0);
      check("reset_p2_async", p2_score, 0);
      tick();
      tick();
      check("reset_p1_held", p1_score, 0);
      check("reset_p2_held", p2_score, 0);
      reset = 1'b0;
      tick();
      check("after_reset_p1", p1_score, 0);

      // Ball travels right inside the field, then crosses the right edge.
      for (int x = 325; x <= 635; x += 5) begin
         ball_x = 10'(x);
         tick();
      end
      check("in_field_p1", p1_score, 0);
      check("in_field_p2", p2_score, 0);
      ball_x = 10'd640;
      tick();
      check("right_miss_p1", p1_score, 1);
      ball_x = 10'd645;
      tick();
      check("right_645_p1", p1_score, 1);
      for (int i = 0; i < 10; i++) tick();
      check("right_hold_p1", p1_score, 1);
      check("right_hold_p2", p2_score, 0);

      // Back to centre, then drift left to zero and wrap.
      ball_x = 10'd320;
      tick();
      ball_direction = 2'b00;
      for (int x = 315; x >= 5; x -= 5) begin
         ball_x = 10'(x);
         tick();
      end
      check("left_in_field_p2", p2_score, 0);
      ball_x = 10'd0;
      tick();
      check("left_miss_p2", p2_score, 1);
      ball_x = 10'd1019;
      tick();
      check("left_wrap_p2", p2_score, 1);
      check("left_wrap_p1", p1_score, 1);

      // Repeated right misses up to saturation; y_dir set on one of them.
      miss_right(2'b10);
      check("rearm_p1_2", p1_score, 2);
      miss_right(2'b11);
      check("y_dir_ignored_p1_3", p1_score, 3);
      for (int s = 4; s <= 9; s++) begin
         miss_right(2'b10);
         check("climb_p1", p1_score, s);
      end
      miss_right(2'b10);
      check("saturate_p1", p1_score, 9);
      check("saturate_p2", p2_score, 1);

      // Direction toggling while out and disarmed awards nothing.
      ball_x = 10'd700;
      for (int i = 0; i < 8; i++) begin
         ball_direction = {~ball_direction[1], 1'b0};
         tick();
      end
      check("toggle_p1", p1_score, 9);
      check("toggle_p2", p2_score, 1);
      miss_left();
      check("toggle_rearm_p2", p2_score, 2);

      // Build p1=3, p2=2, then pulse reset between edges.
      ball_x = 10'd320;
      ball_direction = 2'b10;
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      tick();
      check("midgame_clear_p1", p1_score, 0);
      for (int i = 0; i < 3; i++) miss_right(2'b10);
      miss_left();
      miss_left();
      check("pre_pulse_p1", p1_score, 3);
      check("pre_pulse_p2", p2_score, 2);
      ball_x = 10'd320;
      ball_direction = 2'b10;
      #2 reset = 1'b1;
      #1;
      check("pulse_async_p1", p1_score, 0);
      check("pulse_async_p2", p2_score, 0);
      #1 reset = 1'b0;
      tick();
      check("pulse_after_p1", p1_score, 0);

      // Ball still out when reset releases: one point on the next edge.
      ball_x = 10'd640;
      tick();
      check("out_pre_reset_p1", p1_score, 1);
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      check("out_reset_p1", p1_score, 0);
      tick();
      check("out_after_reset_p1", p1_score, 1);
      tick();
      tick();
      check("out_after_reset_hold_p1", p1_score, 1);
      check("out_after_reset_p2", p2_score, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
